// File: rtl/ramp_decoder.sv
// ramp_decoder: watches a free-running ramp sample stream and decodes each
// sample-to-sample step. Steps of 1, 16 or 1290 (modulo 2^RAMP_W) are legal
// and produce codes 01, 10 and 11. A step of 0 is a hold. Anything else is
// illegal and sends the block to a sticky ERROR state. The exception is a
// jump to 0 while locked, which is taken as a source restart.
//
// Ports:
//   clk       - master clock, rising edge
//   rst_n     - synchronous reset, active HIGH despite the name
//   dec_enb   - decoder enable; low forces IDLE and clears state
//   ramp_in   - ramp sample, taken every clock
//   delta_out - one-cycle pulse per legal step
//   Y_out     - code of the last legal step (00 only after reset/IDLE)
//   step_cnt  - legal steps since lock, saturating at 4095
//   locked    - high while in LOCKED
//   wrap      - pulses with delta_out when the step carried out of RAMP_W bits
//   y_chg     - pulses with delta_out when the step code changed Y_out
//   err       - high while in ERROR
module ramp_decoder #(
    parameter int unsigned RAMP_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_enb,
    input  logic [RAMP_W-1:0] ramp_in,
    output logic              delta_out,
    output logic [1:0]        Y_out,
    output logic [11:0]       step_cnt,
    output logic              locked,
    output logic              wrap,
    output logic              y_chg,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StAcquire, StLocked, StError} state_e;

    state_e            state_q, state_d;
    logic [RAMP_W-1:0] prev_q, prev_d;
    logic [1:0]        y_d;
    logic [11:0]       cnt_d;
    logic              delta_d, wrap_d, ychg_d;

    logic [RAMP_W-1:0] diff;
    logic [1:0]        code;
    logic              is_hold, is_legal, is_illegal, is_restart, is_wrap;

    // Step classification. Legality is decided before restart, so a
    // 4095 -> 0 transition is an ordinary +1 step with wrap.
    always_comb begin
        diff = ramp_in - prev_q;
        code = 2'b00;
        if (diff == RAMP_W'(1)) begin
            code = 2'b01;
        end else if (diff == RAMP_W'(16)) begin
            code = 2'b10;
        end else if (diff == RAMP_W'(1290)) begin
            code = 2'b11;
        end
        is_hold    = (diff == '0);
        is_legal   = (code != 2'b00);
        is_illegal = !is_hold && !is_legal;
        is_restart = (ramp_in == '0);
        is_wrap    = (ramp_in < prev_q);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= StIdle;
            prev_q    <= '0;
            Y_out     <= 2'b00;
            step_cnt  <= '0;
            delta_out <= 1'b0;
            wrap      <= 1'b0;
            y_chg     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            Y_out     <= y_d;
            step_cnt  <= cnt_d;
            delta_out <= delta_d;
            wrap      <= wrap_d;
            y_chg     <= ychg_d;
        end
    end

    // Next state and next register values.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        y_d     = Y_out;
        cnt_d   = step_cnt;
        delta_d = 1'b0;
        wrap_d  = 1'b0;
        ychg_d  = 1'b0;

        if (!dec_enb) begin
            state_d = StIdle;
            prev_d  = '0;
            y_d     = 2'b00;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    prev_d  = ramp_in;
                    state_d = StAcquire;
                end
                StAcquire: begin
                    prev_d = ramp_in;
                    if (is_legal) begin
                        state_d = StLocked;
                        y_d     = code;
                        cnt_d   = 12'd1;
                        delta_d = 1'b1;
                        wrap_d  = is_wrap;
                    end else if (is_illegal) begin
                        state_d = StError;
                    end
                end
                StLocked: begin
                    prev_d = ramp_in;
                    if (is_legal) begin
                        delta_d = 1'b1;
                        wrap_d  = is_wrap;
                        if (step_cnt != 12'hfff) begin
                            cnt_d = step_cnt + 12'd1;
                        end
                        if (code != Y_out) begin
                            y_d    = code;
                            ychg_d = 1'b1;
                        end
                    end else if (is_illegal && is_restart) begin
                        state_d = StAcquire;
                        cnt_d   = '0;
                    end else if (is_illegal) begin
                        state_d = StError;
                    end
                end
                default: begin
                    // StError is sticky until the enable drops.
                    state_d = StError;
                end
            endcase
        end
    end

    // Level outputs decoded straight from the state register.
    always_comb begin
        locked = (state_q == StLocked);
        err    = (state_q == StError);
    end

endmodule

// File: doc/ramp_decoder.md
RAMP_DECODER -- requirements
Module: ramp_decoder

Interface
REQ-001 The block SHALL have the parameter RAMP_W, default 12, which sets the ramp sample width in bits.
REQ-002 The block SHALL have the port clk, input, 1 bit: master clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port dec_enb, input, 1 bit: active-high decoder enable.
REQ-005 The block SHALL have the port ramp_in, input, RAMP_W bits: ramp sample taken every clock.
REQ-006 The block SHALL have the port delta_out, output, 1 bit: one-cycle pulse per detected step.
REQ-007 The block SHALL have the port Y_out, output, 2 bits: decoded step code (01=1, 10=16, 11=1290).
REQ-008 The block SHALL have the port step_cnt, output, 12 bits: steps since lock, saturating.
REQ-009 The block SHALL have the port locked, output, 1 bit: high while in LOCKED.
REQ-010 The block SHALL have the port wrap, output, 1 bit: one-cycle pulse when a legal step wraps modulo 2^RAMP_W.
REQ-011 The block SHALL have the port y_chg, output, 1 bit: one-cycle pulse when a legal step code differs from the current Y_out.
REQ-012 The block SHALL have the port err, output, 1 bit: high while in ERROR.

Function
REQ-013 The block SHALL register all outputs; a response appears one clk after the rising edge that samples the triggering ramp_in.
REQ-014 The block SHALL hold register prev (RAMP_W bits) and compute diff = (ramp_in - prev) mod 2^RAMP_W.
REQ-015 diff SHALL be classified as: 0 = hold; 1, 16 or 1290 = legal with codes 01, 10 and 11; any other value = illegal.
REQ-016 The state machine SHALL have the states IDLE, ACQUIRE, LOCKED and ERROR.
REQ-017 In any state, dec_enb=0 SHALL force IDLE next cycle and clear prev, Y_out and step_cnt; this has priority over all other transitions.
REQ-018 In IDLE with dec_enb=1, the block SHALL load prev with ramp_in and go to ACQUIRE; it SHALL produce no pulses in that cycle.
REQ-019 In ACQUIRE, hold SHALL keep the state.
REQ-020 In ACQUIRE, legal SHALL set Y_out to the code, pulse delta_out, set step_cnt=1 and go to LOCKED.
REQ-021 In ACQUIRE, illegal SHALL go to ERROR.
REQ-022 In LOCKED, hold SHALL produce no pulses and no change.
REQ-023 In LOCKED, legal SHALL pulse delta_out and increment step_cnt, saturating at 4095.
REQ-024 In LOCKED, a legal step with a code different from Y_out SHALL also update Y_out and pulse y_chg in the same cycle.
REQ-025 In LOCKED, an illegal diff with ramp_in=0 SHALL be treated as a source restart: clear step_cnt, keep Y_out and go to ACQUIRE.
REQ-026 In LOCKED, any other illegal diff SHALL go to ERROR.
REQ-027 ERROR SHALL be sticky: it holds until dec_enb=0 or reset, and delta_out, wrap and y_chg SHALL stay 0 in ERROR.
REQ-028 wrap SHALL pulse together with delta_out when a legal step has ramp_in < prev, i.e. the sum carried out of RAMP_W bits.
REQ-029 In ACQUIRE and LOCKED, prev SHALL load ramp_in every enabled cycle.
REQ-030 Classification SHALL check legality before restart, so prev=4095 followed by ramp_in=0 (diff 1) is a legal step with wrap, not a restart.
REQ-031 A diff of 0 SHALL never be decoded as code 00; Y_out=00 SHALL occur only after reset or in IDLE.
REQ-032 When step_cnt=4095 and a legal step arrives, step_cnt SHALL stay 4095 and delta_out SHALL still pulse.

Reset
REQ-033 With rst_n=1 at a clk edge, the block SHALL enter IDLE and set prev=0, Y_out=00, step_cnt=0 and delta_out, wrap, y_chg, locked and err all 0.
REQ-034 Reset SHALL override dec_enb and all in-flight decoding.
REQ-035 The first decode after reset SHALL be no earlier than the second enabled cycle after rst_n falls.

Verification
REQ-036 dec_enb=1; ramp_in=0, 0, 16, 32, 48 -> LOCKED after 16, Y_out=10, three delta_out pulses, step_cnt=3.
REQ-037 ramp_in=0, 1290, 2580, 3870, 1064 -> Y_out=11, four delta_out pulses, wrap pulses only with 1064, step_cnt=4.
REQ-038 Locked at code 01 on 5, 6; then ramp_in=22 -> Y_out=10, y_chg and delta_out pulse together, step_cnt=2.
REQ-039 Locked at 100; ramp_in=103 -> err=1 next cycle, no delta_out; err held until dec_enb=0, then IDLE with all outputs 0.
REQ-040 Locked at 2000; ramp_in=0 -> ACQUIRE, step_cnt=0, locked=0, no err; then ramp_in=16 -> relock, step_cnt=1.
REQ-041 prev=4095 locked at code 01; ramp_in=0 -> delta_out and wrap pulse, no restart; rst_n=1 mid-run -> all outputs at reset values next cycle.
